// File: rtl/stack_access_unit.sv
// 6502 stack pointer owner: sequences multi-byte pushes/pulls against the stack page
// and hands the memory arbiter full 16-bit addresses {STACK_PAGE, S}.
//
// state    | meaning
// IDLE     | ready for a command
// PUSH     | write request outstanding at {page,S}; S decrements on ack
// PULL_INC | pre-increment S before a read, no bus request
// PULL_RD  | read request outstanding at {page,S}
// DONE     | rsp_valid pulse, back to IDLE next cycle
module stack_access_unit #(
    parameter logic [7:0] STACK_PAGE = 8'h01,
    parameter logic [7:0] RESET_SP   = 8'hFD
) (
    input  logic        phi2,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_count,
    input  logic [23:0] cmd_data,
    output logic        rsp_valid,
    output logic [23:0] rsp_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [7:0]  sp_out,
    output logic        sp_wrap
);

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        PULL_INC,
        PULL_RD,
        DONE
    } state_t;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_PULL = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;

    state_t      state;
    logic [7:0]  sp;
    logic [1:0]  byteCount;
    logic [1:0]  byteIdx;
    logic [1:0]  nextIdx;
    logic [23:0] pushData;

    function automatic logic [7:0] pickByte(input logic [23:0] d, input logic [1:0] k);
        case (k)
            2'd0:    pickByte = d[7:0];
            2'd1:    pickByte = d[15:8];
            default: pickByte = d[23:16];
        endcase
    endfunction

    assign nextIdx  = byteIdx + 2'd1;
    assign mem_addr = {STACK_PAGE, sp};
    assign sp_out   = sp;

    always_ff @(posedge phi2) begin
        if (reset) begin
            state     <= IDLE;
            sp        <= RESET_SP;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= 24'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= 8'h00;
            sp_wrap   <= 1'b0;
            byteCount <= 2'd0;
            byteIdx   <= 2'd0;
            pushData  <= 24'h0;
        end else begin
            rsp_valid <= 1'b0;
            sp_wrap   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        byteCount <= cmd_count;
                        pushData  <= cmd_data;
                        rsp_data  <= 24'h0;
                        byteIdx   <= 2'd0;
                        cmd_ready <= 1'b0;
                        if (cmd_op == OP_PUSH && cmd_count != 2'd0) begin
                            state     <= PUSH;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_wdata <= pickByte(cmd_data, cmd_count - 2'd1);
                        end else if (cmd_op == OP_PULL && cmd_count != 2'd0) begin
                            state <= PULL_INC;
                        end else begin
                            if (cmd_op == OP_LOAD)
                                sp <= cmd_data[7:0];
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                        end
                    end
                end

                PUSH: begin
                    if (mem_ack) begin
                        sp      <= sp - 8'd1;
                        sp_wrap <= (sp == 8'h00);
                        if (nextIdx == byteCount) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            mem_req   <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_wdata <= 8'h00;
                        end else begin
                            byteIdx   <= nextIdx;
                            // highest byte goes first, so the index walks downward
                            mem_wdata <= pickByte(pushData, byteCount - 2'd2 - byteIdx);
                        end
                    end
                end

                PULL_INC: begin
                    sp      <= sp + 8'd1;
                    sp_wrap <= (sp == 8'hFF);
                    state   <= PULL_RD;
                    mem_req <= 1'b1;
                    mem_we  <= 1'b0;
                end

                PULL_RD: begin
                    if (mem_ack) begin
                        case (byteIdx)
                            2'd0:    rsp_data[7:0]   <= mem_rdata;
                            2'd1:    rsp_data[15:8]  <= mem_rdata;
                            default: rsp_data[23:16] <= mem_rdata;
                        endcase
                        mem_req <= 1'b0;
                        if (nextIdx == byteCount) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                        end else begin
                            byteIdx <= nextIdx;
                            state   <= PULL_INC;
                        end
                    end
                end

                DONE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end

                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_access_unit.sv
// Directed bench for stack_access_unit: a stack-page memory model answers the bus
// with programmable ack delay and checks every access against the expected sequence.
module tb_stack_access_unit;

    logic        phi2;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_count;
    logic [23:0] cmd_data;
    logic        rsp_valid;
    logic [23:0] rsp_data;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [7:0]  sp_out;
    logic        sp_wrap;

    stack_access_unit dut (
        .phi2(phi2), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_count(cmd_count), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .sp_out(sp_out), .sp_wrap(sp_wrap)
    );

    initial phi2 = 1'b0;
    always #5 phi2 = ~phi2;

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wd;
    } access_t;

    access_t     expQ[$];
    logic [7:0]  modelMem [256];
    logic [7:0]  spModel;
    logic [7:0]  expS;
    logic [23:0] expRsp;
    int          expWrap;
    int          expLat;
    int          ackDelay;
    logic        noiseAck;
    int          wrapCnt;
    int          waitCnt;
    logic        pendValid;
    logic [15:0] pendAddr;
    logic        pendWe;
    logic [7:0]  pendWd;
    int          checks;
    int          fails;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected bus accesses, final S, pulled data, wraps and latency for one command.
    task automatic modelCmd(input logic [1:0] op, input logic [1:0] cnt,
                            input logic [23:0] data, input int delay);
        logic [7:0]  s;
        logic [23:0] tmp;
        access_t     a;
        int          n;
        s = spModel;
        n = int'(cnt);
        expQ.delete();
        expRsp  = 24'h0;
        expWrap = 0;
        expLat  = 1;
        if (op == 2'b00 && n != 0) begin
            for (int k = 0; k < n; k++) begin
                tmp    = data >> (8 * (n - 1 - k));
                a.addr = {8'h01, s};
                a.we   = 1'b1;
                a.wd   = tmp[7:0];
                expQ.push_back(a);
                modelMem[s] = tmp[7:0];
                if (s == 8'h00) expWrap++;
                s = s - 8'd1;
            end
            expLat = n * (1 + delay) + 1;
        end else if (op == 2'b01 && n != 0) begin
            for (int k = 0; k < n; k++) begin
                if (s == 8'hFF) expWrap++;
                s      = s + 8'd1;
                a.addr = {8'h01, s};
                a.we   = 1'b0;
                a.wd   = 8'h00;
                expQ.push_back(a);
                expRsp = expRsp | (24'(modelMem[s]) << (8 * k));
            end
            expLat = n * (2 + delay) + 1;
        end else if (op == 2'b10) begin
            s = data[7:0];
        end
        expS    = s;
        spModel = s;
    endtask

    // Memory responder and per-cycle bus checker.
    always @(negedge phi2) begin
        if (reset) begin
            mem_ack   = 1'b0;
            waitCnt   = 0;
            pendValid = 1'b0;
        end else begin
            if (mem_req) begin
                check("req_while_ready", {31'd0, cmd_ready}, 32'd0);
                if (pendValid)
                    check("held_access", {7'd0, mem_addr, mem_we, mem_we ? mem_wdata : 8'h00},
                          {7'd0, pendAddr, pendWe, pendWe ? pendWd : 8'h00});
                if (expQ.size() == 0) begin
                    check("unexpected_req", {16'd0, mem_addr}, 32'd0);
                end else begin
                    check("bus_access",
                          {7'd0, mem_addr, mem_we, mem_we ? mem_wdata : 8'h00},
                          {7'd0, expQ[0].addr, expQ[0].we, expQ[0].we ? expQ[0].wd : 8'h00});
                end
                if (waitCnt >= ackDelay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_we ? 8'h00 : modelMem[mem_addr[7:0]];
                    if (expQ.size() != 0) void'(expQ.pop_front());
                    waitCnt   = 0;
                    pendValid = 1'b0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 8'hEE;
                    waitCnt++;
                    pendValid = 1'b1;
                    pendAddr  = mem_addr;
                    pendWe    = mem_we;
                    pendWd    = mem_wdata;
                end
            end else begin
                mem_ack   = noiseAck;
                mem_rdata = 8'h5A;
                pendValid = 1'b0;
                waitCnt   = 0;
            end
            if (sp_wrap) wrapCnt++;
        end
    end

    task automatic runCmd(input string name, input logic [1:0] op, input logic [1:0] cnt,
                          input logic [23:0] data, input int delay);
        int lat;
        modelCmd(op, cnt, data, delay);
        ackDelay = delay;
        wrapCnt  = 0;
        check({name, "_ready"}, {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = cnt;
        cmd_data  = data;
        @(posedge phi2);
        lat = 0;
        forever begin
            @(negedge phi2);
            // garbage command while busy must be ignored
            cmd_valid = 1'b1;
            cmd_op    = 2'b00;
            cmd_count = 2'd3;
            cmd_data  = 24'hDEAD01;
            lat++;
            if (rsp_valid) break;
            if (lat > 100) begin
                check({name, "_timeout"}, 32'(lat), 32'(expLat));
                break;
            end
        end
        cmd_valid = 1'b0;
        check({name, "_latency"}, 32'(lat), 32'(expLat));
        check({name, "_rsp_data"}, {8'd0, rsp_data}, {8'd0, expRsp});
        check({name, "_sp"}, {24'd0, sp_out}, {24'd0, expS});
        check({name, "_accesses_left"}, 32'(expQ.size()), 32'd0);
        @(negedge phi2);
        check({name, "_wraps"}, 32'(wrapCnt), 32'(expWrap));
        check({name, "_rsp_pulse"}, {31'd0, rsp_valid}, 32'd0);
        check({name, "_ready_after"}, {31'd0, cmd_ready}, 32'd1);
        check({name, "_rsp_hold"}, {8'd0, rsp_data}, {8'd0, expRsp});
    endtask

    initial begin
        int seen;
        checks    = 0;
        fails     = 0;
        wrapCnt   = 0;
        waitCnt   = 0;
        pendValid = 1'b0;
        ackDelay  = 0;
        noiseAck  = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        cmd_valid = 1'b0;
        cmd_op    = 2'b11;
        cmd_count = 2'd0;
        cmd_data  = 24'h0;
        for (int i = 0; i < 256; i++) modelMem[i] = 8'(i) ^ 8'hA5;
        spModel = 8'hFD;
        reset   = 1'b1;
        repeat (2) @(posedge phi2);
        @(negedge phi2);
        check("reset_sp", {24'd0, sp_out}, 32'h0000_00FD);
        check("reset_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset_req", {31'd0, mem_req}, 32'd0);
        check("reset_addr", {16'd0, mem_addr}, 32'h0000_01FD);
        check("reset_rsp", {7'd0, rsp_valid, rsp_data}, 32'd0);
        check("reset_wrap", {30'd0, sp_wrap, mem_we}, 32'd0);
        reset = 1'b0;
        @(negedge phi2);

        runCmd("push2", 2'b00, 2'd2, 24'h001234, 0);
        check("push2_pin_sp", {24'd0, sp_out}, 32'h0000_00FB);
        check("push2_pin_mem", {16'd0, modelMem[8'hFD], modelMem[8'hFC]}, 32'h0000_1234);

        runCmd("pull2", 2'b01, 2'd2, 24'h0, 0);
        check("pull2_pin_rsp", {8'd0, rsp_data}, 32'h0000_1234);
        check("pull2_pin_sp", {24'd0, sp_out}, 32'h0000_00FD);

        runCmd("load00", 2'b10, 2'd0, 24'hABCD00, 0);
        runCmd("push1_wait2", 2'b00, 2'd1, 24'h000055, 2);
        check("push1_pin_sp", {24'd0, sp_out}, 32'h0000_00FF);
        check("push1_pin_wrap", 32'(wrapCnt), 32'd1);

        runCmd("loadFE", 2'b10, 2'd3, 24'h0000FE, 0);
        runCmd("pull3_rti", 2'b01, 2'd3, 24'h0, 0);
        check("pull3_pin_sp", {24'd0, sp_out}, 32'h0000_0001);
        check("pull3_pin_byte1", {24'd0, rsp_data[15:8]}, 32'h0000_0055);

        noiseAck = 1'b1;
        runCmd("push3_wait1", 2'b00, 2'd3, 24'hA1B2C3, 1);
        runCmd("pull3_wait1", 2'b01, 2'd3, 24'h0, 1);
        check("pull3_pin_order", {8'd0, rsp_data}, 32'h00A1_B2C3);
        noiseAck = 1'b0;

        runCmd("push0", 2'b00, 2'd0, 24'h123456, 0);
        runCmd("pull0", 2'b01, 2'd0, 24'h0, 0);
        runCmd("noop", 2'b11, 2'd2, 24'h0000AA, 0);
        runCmd("loadFF", 2'b10, 2'd1, 24'h0000FF, 0);
        runCmd("pull1_wrap", 2'b01, 2'd1, 24'h0, 0);
        check("pull1_pin_sp", {24'd0, sp_out}, 32'h0000_0000);

        // reset while the second push byte is outstanding
        runCmd("loadFD", 2'b10, 2'd0, 24'h0000FD, 0);
        modelCmd(2'b00, 2'd2, 24'h00BEEF, 3);
        ackDelay  = 3;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_count = 2'd2;
        cmd_data  = 24'h00BEEF;
        @(posedge phi2);
        @(negedge phi2);
        cmd_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req && mem_addr == 16'h01FC) begin
                seen = 1;
                break;
            end
            @(negedge phi2);
        end
        check("rst_mid_second_byte_seen", 32'(seen), 32'd1);
        reset = 1'b1;
        @(posedge phi2);
        @(negedge phi2);
        check("rst_mid_req", {31'd0, mem_req}, 32'd0);
        check("rst_mid_sp", {24'd0, sp_out}, 32'h0000_00FD);
        check("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);
        reset = 1'b0;
        expQ.delete();
        spModel = 8'hFD;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge phi2);
            if (rsp_valid || mem_req) seen++;
        end
        check("rst_mid_quiet", 32'(seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
